bmc_soft_pipe: RTL

Parametrised soft/hard-decision branch metric unit for the Viterbi decoder, feeding the add-compare-select array. Per accepted received beat of N_OUT code symbols it computes, for every one of the 2^N_OUT candidate codewords, the branch metric against the received symbols. Metrics are normalised so the smallest is 0, and per-symbol depuncture erasures are honoured. It is a 2-stage valid/ready pipeline with a saturating erasure counter.

---
 rtl/bmc_pkg.sv | 38 +++
 rtl/bmc_soft_pipe_if.sv | 36 +++
 rtl/bmc_sym_dist.sv | 40 ++++
 rtl/bmc_soft_pipe.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bmc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : bmc_pkg                                                    |
// | Description : Shared types and helpers for the Viterbi branch metric     |
// |               unit: metric width, codeword bit lookup, soft full-scale   |
// |               value and the per-symbol distance pair.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package bmc_pkg;

    // Widest soft symbol the unit supports; distance fields are sized to it
    // so one struct type serves every legal SOFT_W.
    localparam int SOFT_W_MAX = 6;
    localparam int DIST_W     = SOFT_W_MAX;

    // Distance of one received symbol to an expected '0' and an expected '1'.
    typedef struct packed {
        logic [DIST_W-1:0] d1;
        logic [DIST_W-1:0] d0;
    } dist_pair_t;

    // Metric width: N_OUT full-scale distances summed without overflow.
    function automatic int bm_width(input int n_out, input int soft_w);
        return soft_w + $clog2(n_out);
    endfunction

    // Full-scale (strong '1') soft value for a given symbol width.
    function automatic int soft_max(input int soft_w);
        return (1 << soft_w) - 1;
    endfunction

    // Expected code bit of symbol i in candidate codeword k.
    function automatic logic cw_bit(input int k, input int i);
        return ((k >> i) & 1) != 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmc_soft_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : bmc_soft_pipe_if                                           |
// | Description : Input beat and output metric handshakes of the branch      |
// |               metric unit. master = beat source / metric sink side,      |
// |               slave = branch metric unit side.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface bmc_soft_pipe_if #(
    parameter int N_OUT  = 2,
    parameter int SOFT_W = 3,
    parameter int BM_W   = bmc_pkg::bm_width(N_OUT, SOFT_W)
);

    logic                         in_valid;
    logic                         in_ready;
    logic [N_OUT*SOFT_W-1:0]      rx_soft;
    logic [N_OUT-1:0]             erase_mask;
    logic                         hard_mode;
    logic                         out_valid;
    logic                         out_ready;
    logic [(2**N_OUT)*BM_W-1:0]   bm_o;
    logic [BM_W-1:0]              bm_min_o;

    modport master (
        output in_valid, rx_soft, erase_mask, hard_mode, out_ready,
        input  in_ready, out_valid, bm_o, bm_min_o
    );

    modport slave (
        input  in_valid, rx_soft, erase_mask, hard_mode, out_ready,
        output in_ready, out_valid, bm_o, bm_min_o
    );

endinterface
`default_nettype wire

// File: rtl/bmc_sym_dist.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bmc_sym_dist                                               |
// | Description : Combinational distance of one received symbol to an        |
// |               expected '0' and '1' in soft or hard mode; erased symbols  |
// |               contribute nothing.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bmc_sym_dist
    import bmc_pkg::*;
#(
    parameter int SOFT_W = 3
) (
    input  logic [SOFT_W-1:0] sym_i,
    input  logic              hard_i,
    input  logic              erase_i,
    output dist_pair_t        dist_o
);

    localparam logic [SOFT_W-1:0] SYM_MAX = SOFT_W'(soft_max(SOFT_W));

    logic [SOFT_W-1:0] sym_inv;

    // Select soft, hard or erased distance pair; erasure overrides the mode
    always_comb begin
        dist_o  = '0;
        sym_inv = SYM_MAX - sym_i;
        if (erase_i) begin
            dist_o = '0;
        end else if (hard_i) begin
            dist_o.d0 = DIST_W'(sym_i[SOFT_W-1]);
            dist_o.d1 = DIST_W'(!sym_i[SOFT_W-1]);
        end else begin
            dist_o.d0 = DIST_W'(sym_i);
            dist_o.d1 = DIST_W'(sym_inv);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bmc_soft_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bmc_soft_pipe                                              |
// | Description : Two-stage valid/ready branch metric unit. Stage 1 holds    |
// |               per-symbol distances, stage 2 the min-normalised metrics   |
// |               of all 2^N_OUT codewords. Saturating erasure counter.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bmc_soft_pipe
    import bmc_pkg::*;
#(
    parameter int N_OUT  = 2,
    parameter int SOFT_W = 3,
    parameter int BM_W   = bm_width(N_OUT, SOFT_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bmc_soft_pipe_if.slave       bus,
    input  logic                 cnt_clr,
    output logic [15:0]          erase_cnt
);

    localparam int NCW   = 2**N_OUT;
    // Internal metric width covers four symbols at the widest distance, so
    // the adder chain never wraps before the final narrowing to BM_W.
    localparam int MET_W = DIST_W + 2;
    localparam int POP_W = $clog2(N_OUT + 1);

    // Handshake
    logic adv;
    logic accept;

    // Pipeline state
    dist_pair_t [N_OUT-1:0]   dist_w;
    dist_pair_t [N_OUT-1:0]   dist_d, dist_q;
    logic                     s1_valid_d, s1_valid_q;
    logic                     out_valid_d, out_valid_q;
    logic [NCW*BM_W-1:0]      bm_d, bm_q;
    logic [BM_W-1:0]          bm_min_d, bm_min_q;

    // Metric datapath
    logic [MET_W-1:0]         met [NCW];
    logic [MET_W-1:0]         met_min;
    logic [NCW*BM_W-1:0]      norm;

    // Erasure counter
    logic [POP_W-1:0]         pop;
    logic [16:0]              cnt_sum;
    logic [15:0]              erase_cnt_d, erase_cnt_q;

    // One distance unit per received symbol, ahead of the stage-1 register
    for (genvar i = 0; i < N_OUT; i++) begin : g_sym
        bmc_sym_dist #(
            .SOFT_W (SOFT_W)
        ) u_sym_dist (
            .sym_i   (bus.rx_soft[i*SOFT_W +: SOFT_W]),
            .hard_i  (bus.hard_mode),
            .erase_i (bus.erase_mask[i]),
            .dist_o  (dist_w[i])
        );
    end

    // Whole pipe advances together whenever the output slot is free
    always_comb begin
        adv    = !out_valid_q || bus.out_ready;
        accept = bus.in_valid && adv;
    end

    // Raw metric of each candidate codeword from the registered distances
    always_comb begin
        for (int k = 0; k < NCW; k++) begin
            met[k] = '0;
            for (int i = 0; i < N_OUT; i++) begin
                met[k] = met[k] + (cw_bit(k, i) ? MET_W'(dist_q[i].d1)
                                                : MET_W'(dist_q[i].d0));
            end
        end
    end

    // Smallest metric and normalisation so the best codeword scores 0
    always_comb begin
        met_min = met[0];
        for (int k = 1; k < NCW; k++) begin
            if (met[k] < met_min) begin
                met_min = met[k];
            end
        end
        norm = '0;
        for (int k = 0; k < NCW; k++) begin
            norm[k*BM_W +: BM_W] = BM_W'(met[k] - met_min);
        end
    end

    // Stage advance; bubbles travel through, outputs only update on real beats
    always_comb begin
        s1_valid_d  = s1_valid_q;
        dist_d      = dist_q;
        out_valid_d = out_valid_q;
        bm_d        = bm_q;
        bm_min_d    = bm_min_q;
        if (adv) begin
            s1_valid_d  = bus.in_valid;
            out_valid_d = s1_valid_q;
            if (bus.in_valid) begin
                dist_d = dist_w;
            end
            if (s1_valid_q) begin
                bm_d     = norm;
                bm_min_d = BM_W'(met_min);
            end
        end
    end

    // Erasure count: clear wins, otherwise add accepted erasures and saturate
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_OUT; i++) begin
            pop = pop + POP_W'(bus.erase_mask[i]);
        end
        cnt_sum     = {1'b0, erase_cnt_q} + 17'(pop);
        erase_cnt_d = erase_cnt_q;
        if (cnt_clr) begin
            erase_cnt_d = '0;
        end else if (accept) begin
            erase_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    // State registers with asynchronous reset discarding in-flight beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            dist_q      <= '0;
            out_valid_q <= 1'b0;
            bm_q        <= '0;
            bm_min_q    <= '0;
            erase_cnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            dist_q      <= dist_d;
            out_valid_q <= out_valid_d;
            bm_q        <= bm_d;
            bm_min_q    <= bm_min_d;
            erase_cnt_q <= erase_cnt_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.bm_o      = bm_q;
    assign bus.bm_min_o  = bm_min_q;
    assign erase_cnt     = erase_cnt_q;

endmodule
`default_nettype wire
